// File: rtl/btn_conditioner.sv
// Button conditioning: 2-FF synchroniser, counter debouncer, edge pulses and
// an auto-repeat step generator per channel, all in the vga_clk domain.
module btn_conditioner #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned DEBOUNCE_CYC = 250000,
    parameter int unsigned REPEAT_DELAY = 12500000,
    parameter int unsigned REPEAT_RATE  = 2500000
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic [N_BTN-1:0] btn_i,
    input  logic [N_BTN-1:0] repeat_en_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o,
    output logic [N_BTN-1:0] btn_step_o
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

    logic [N_BTN-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] step_q, step_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [TMR_W-1:0] timer_q [N_BTN];
    logic [TMR_W-1:0] timer_d [N_BTN];
    state_e           state_q [N_BTN];
    state_e           state_d [N_BTN];

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            step_q    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i]   <= '0;
                timer_q[i] <= '0;
                state_q[i] <= StIdle;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i]   <= cnt_d[i];
                timer_q[i] <= timer_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // Debouncer; press_d/release_d double as the FSM's press/release events.
    always_comb begin
        s1_d      = btn_i;
        s2_d      = s1_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i]   = s2_q[i];
                    press_d[i]   = s2_q[i];
                    release_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Repeat FSM next state; release wins over a coinciding repeat.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            unique case (state_q[i])
                StIdle: begin
                    timer_d[i] = '0;
                    if (press_d[i]) state_d[i] = StDelay;
                end
                StDelay: begin
                    if (release_d[i]) begin
                        state_d[i] = StIdle;
                        timer_d[i] = '0;
                    end else if (!repeat_en_i[i]) begin
                        timer_d[i] = '0;
                    end else if (timer_q[i] == DELAY_LAST) begin
                        state_d[i] = StRepeat;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                StRepeat: begin
                    if (release_d[i]) begin
                        state_d[i] = StIdle;
                        timer_d[i] = '0;
                    end else if (!repeat_en_i[i] || timer_q[i] == RATE_LAST) begin
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    always_comb begin
        step_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            unique case (state_q[i])
                StIdle:   step_d[i] = press_d[i];
                StDelay:  step_d[i] = !release_d[i] && repeat_en_i[i] &&
                                      (timer_q[i] == DELAY_LAST);
                StRepeat: step_d[i] = !release_d[i] && repeat_en_i[i] &&
                                      (timer_q[i] == RATE_LAST);
                default:  step_d[i] = 1'b0;
            endcase
        end
    end

    assign btn_level_o   = level_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;
    assign btn_step_o    = step_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3.
module tb_btn_conditioner;

    logic       clk;
    logic       resetn;
    logic [3:0] btn;
    logic [3:0] repeat_en;
    logic [3:0] level, press, release_p, step;

    int n_checks = 0;
    int n_errors = 0;

    btn_conditioner #(
        .N_BTN        (4),
        .DEBOUNCE_CYC (4),
        .REPEAT_DELAY (10),
        .REPEAT_RATE  (3)
    ) u_dut (
        .clk_i         (clk),
        .resetn_i      (resetn),
        .btn_i         (btn),
        .repeat_en_i   (repeat_en),
        .btn_level_o   (level),
        .btn_press_o   (press),
        .btn_release_o (release_p),
        .btn_step_o    (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] en);
        resetn    = 1'b0;
        btn       = 4'b0000;
        repeat_en = en;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        resetn    = 1'b0;
        btn       = 4'b0000;
        repeat_en = 4'b0000;

        // 1: reset state, then single press on U
        do_reset(4'b0000);
        check("rst_level", 32'(level), 32'h0);
        check("rst_press", 32'(press), 32'h0);
        check("rst_release", 32'(release_p), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        btn = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("s1_level c%0d", c), 32'(level), (c >= 6) ? 32'h1 : 32'h0);
            check($sformatf("s1_press c%0d", c), 32'(press), (c == 6) ? 32'h1 : 32'h0);
            check($sformatf("s1_step c%0d", c), 32'(step), (c == 6) ? 32'h1 : 32'h0);
            check($sformatf("s1_rel c%0d", c), 32'(release_p), 32'h0);
        end

        // 2: 3-cycle glitch on L is filtered
        do_reset(4'b1111);
        btn = 4'b0010;
        tick();
        tick();
        tick();
        btn = 4'b0000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check($sformatf("s2_quiet c%0d", c), 32'({level, press, release_p, step}), 32'h0);
        end

        // 3: auto-repeat on R, then release (repeat at d6 collides with release)
        do_reset(4'b1111);
        btn = 4'b0100;
        for (int c = 1; c <= 40; c++) begin
            tick();
            check($sformatf("s3_step c%0d", c), 32'(step),
                  (c == 6 || (c >= 16 && (c - 16) % 3 == 0)) ? 32'h4 : 32'h0);
        end
        btn = 4'b0000;
        for (int d = 1; d <= 15; d++) begin
            tick();
            check($sformatf("s3r_step d%0d", d), 32'(step), (d == 3) ? 32'h4 : 32'h0);
            check($sformatf("s3r_rel d%0d", d), 32'(release_p), (d == 6) ? 32'h4 : 32'h0);
            check($sformatf("s3r_level d%0d", d), 32'(level), (d >= 6) ? 32'h0 : 32'h4);
        end

        // 4: repeat disabled on D, then re-enabled while in DELAY
        do_reset(4'b0111);
        btn = 4'b1000;
        for (int c = 1; c <= 30; c++) begin
            tick();
            check($sformatf("s4_step c%0d", c), 32'(step), (c == 6) ? 32'h8 : 32'h0);
        end
        repeat_en = 4'b1111;
        for (int k = 1; k <= 14; k++) begin
            tick();
            check($sformatf("s4e_step k%0d", k), 32'(step),
                  (k == 10 || k == 13) ? 32'h8 : 32'h0);
        end

        // 5: simultaneous press on all, release U only
        do_reset(4'b0000);
        btn = 4'b1111;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check($sformatf("s5_press c%0d", c), 32'(press), (c == 6) ? 32'hF : 32'h0);
            check($sformatf("s5_step c%0d", c), 32'(step), (c == 6) ? 32'hF : 32'h0);
            check($sformatf("s5_level c%0d", c), 32'(level), (c >= 6) ? 32'hF : 32'h0);
        end
        btn = 4'b1110;
        for (int d = 1; d <= 8; d++) begin
            tick();
            check($sformatf("s5r_rel d%0d", d), 32'(release_p), (d == 6) ? 32'h1 : 32'h0);
            check($sformatf("s5r_press d%0d", d), 32'(press), 32'h0);
            check($sformatf("s5r_level d%0d", d), 32'(level), (d >= 6) ? 32'hE : 32'hF);
        end

        // 6: mid-operation reset while U is repeating
        do_reset(4'b1111);
        btn = 4'b0001;
        for (int c = 1; c <= 17; c++) tick();
        resetn = 1'b0;
        tick();
        check("s6_in_reset", 32'({level, press, release_p, step}), 32'h0);
        resetn = 1'b1;
        for (int r = 1; r <= 8; r++) begin
            tick();
            check($sformatf("s6_press r%0d", r), 32'(press), (r == 6) ? 32'h1 : 32'h0);
            check($sformatf("s6_step r%0d", r), 32'(step), (r == 6) ? 32'h1 : 32'h0);
            check($sformatf("s6_level r%0d", r), 32'(level), (r >= 6) ? 32'h1 : 32'h0);
            check($sformatf("s6_rel r%0d", r), 32'(release_p), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
